// File: rtl/cart_ram_upload_if.sv
// -----------------------------------------------------------------------------
// cart_ram_upload_if
// Groups the two handshakes the upload block sits between:
//   - hps_io ioctl upload side : IOCTL_UPLOAD, IOCTL_INDEX, IOCTL_RD, IOCTL_ADDR
//                                 (to block), IOCTL_DIN, IOCTL_WAIT (from block)
//   - cart RAM read port        : SRAM_ADDR, SRAM_RD (from block),
//                                 SRAM_DATA, SRAM_VALID (to block)
// Modports:
//   master - the environment (hps_io + RAM arbiter) driving requests and data
//   slave  - cart_ram_upload itself
// -----------------------------------------------------------------------------
interface cart_ram_upload_if #(
    parameter int RAM_AW = 13
);
    logic              IOCTL_UPLOAD;
    logic [7:0]        IOCTL_INDEX;
    logic              IOCTL_RD;
    logic [24:0]       IOCTL_ADDR;
    logic [7:0]        IOCTL_DIN;
    logic              IOCTL_WAIT;
    logic [RAM_AW-1:0] SRAM_ADDR;
    logic              SRAM_RD;
    logic [7:0]        SRAM_DATA;
    logic              SRAM_VALID;

    modport master (
        output IOCTL_UPLOAD, IOCTL_INDEX, IOCTL_RD, IOCTL_ADDR,
        output SRAM_DATA, SRAM_VALID,
        input  IOCTL_DIN, IOCTL_WAIT, SRAM_ADDR, SRAM_RD
    );

    modport slave (
        input  IOCTL_UPLOAD, IOCTL_INDEX, IOCTL_RD, IOCTL_ADDR,
        input  SRAM_DATA, SRAM_VALID,
        output IOCTL_DIN, IOCTL_WAIT, SRAM_ADDR, SRAM_RD
    );
endinterface

// File: rtl/cart_ram_upload.sv
// -----------------------------------------------------------------------------
// cart_ram_upload
// Serves cartridge battery RAM to hps_io over the ioctl upload interface and
// decides when a save is worth requesting.
//   CLK_SYS      in   system clock
//   RESET        in   asynchronous reset, active high
//   ENABLE       in   mapper has battery RAM
//   CART_RAM_WE  in   CPU write strobe to cart RAM (one pulse per write)
//   bus          slave modport: ioctl upload handshake + RAM read port
//   UPLOAD_REQ   out  ask the HPS to start a save
//   DIRTY        out  RAM modified since the last complete upload
//   TIMEOUT_ERR  out  sticky flag: a RAM fetch never returned data
// Each in-range read strobe stalls hps_io (IOCTL_WAIT) while the byte is
// fetched through the shared, variable-latency RAM port.
// -----------------------------------------------------------------------------
module cart_ram_upload #(
    parameter int          RAM_AW      = 13,
    parameter logic [7:0]  SAVE_INDEX  = 8'd1,
    parameter logic [23:0] QUIET_CYC   = 24'd2_000_000,
    parameter logic [7:0]  TIMEOUT_CYC = 8'd64
) (
    input  logic              CLK_SYS,
    input  logic              RESET,
    input  logic              ENABLE,
    input  logic              CART_RAM_WE,
    cart_ram_upload_if.slave  bus,
    output logic              UPLOAD_REQ,
    output logic              DIRTY,
    output logic              TIMEOUT_ERR
);

    localparam logic [RAM_AW:0] RAM_SIZE = {1'b1, {RAM_AW{1'b0}}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

    state_t            r_state;
    logic [7:0]        r_din;
    logic              r_wait;
    logic              r_sram_rd;
    logic [RAM_AW-1:0] r_sram_addr;
    logic [7:0]        r_tmo_cnt;
    logic              r_tmo_err;
    logic              r_active_d;
    logic [RAM_AW:0]   r_byte_cnt;
    logic              r_tmo_seen;
    logic              r_dirty;
    logic [23:0]       r_quiet;
    logic              r_upload_req;

    logic w_active;
    logic w_in_range;
    logic w_deliver;
    logic w_tmo_hit;
    logic w_rise;
    logic w_fall;

    assign w_active   = bus.IOCTL_UPLOAD && (bus.IOCTL_INDEX == SAVE_INDEX) && ENABLE;
    assign w_in_range = ((bus.IOCTL_ADDR >> RAM_AW) == 25'd0);
    // A byte is handed over only while the upload is still live; a late VALID
    // after an abort is ignored because the FSM is already back in IDLE.
    assign w_deliver  = (r_state == ST_FETCH) && w_active && bus.SRAM_VALID;
    assign w_tmo_hit  = (r_state == ST_FETCH) && w_active && !bus.SRAM_VALID &&
                        (r_tmo_cnt == (TIMEOUT_CYC - 8'd1));
    assign w_rise     = w_active && !r_active_d;
    assign w_fall     = !w_active && r_active_d;

    // Read FSM: accepts ioctl read strobes and fetches one byte from cart RAM.
    always_ff @(posedge CLK_SYS or posedge RESET) begin
        if (RESET) begin
            r_state     <= ST_IDLE;
            r_din       <= 8'hFF;
            r_wait      <= 1'b0;
            r_sram_rd   <= 1'b0;
            r_sram_addr <= '0;
            r_tmo_cnt   <= 8'd0;
            r_tmo_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_active && bus.IOCTL_RD) begin
                        if (w_in_range) begin
                            r_sram_addr <= bus.IOCTL_ADDR[RAM_AW-1:0];
                            r_sram_rd   <= 1'b1;
                            r_wait      <= 1'b1;
                            r_tmo_cnt   <= 8'd0;
                            r_state     <= ST_FETCH;
                        end else begin
                            // Past the end of RAM: answer immediately with blank data.
                            r_din <= 8'hFF;
                        end
                    end
                end
                ST_FETCH: begin
                    if (!w_active) begin
                        r_sram_rd <= 1'b0;
                        r_wait    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (bus.SRAM_VALID) begin
                        r_din     <= bus.SRAM_DATA;
                        r_sram_rd <= 1'b0;
                        r_wait    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (w_tmo_hit) begin
                        r_din     <= 8'hFF;
                        r_tmo_err <= 1'b1;
                        r_sram_rd <= 1'b0;
                        r_wait    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    end
                end
                default: begin
                    r_sram_rd <= 1'b0;
                    r_wait    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    // Save bookkeeping: upload coverage, dirty tracking, quiet timer, save request.
    always_ff @(posedge CLK_SYS or posedge RESET) begin
        if (RESET) begin
            r_active_d   <= 1'b0;
            r_byte_cnt   <= '0;
            r_tmo_seen   <= 1'b0;
            r_dirty      <= 1'b0;
            r_quiet      <= 24'd0;
            r_upload_req <= 1'b0;
        end else begin
            r_active_d <= w_active;

            // Coverage only advances for the next byte in strict ascending order,
            // so a partial or out-of-order upload can never clear DIRTY.
            if (w_rise) begin
                r_byte_cnt <= '0;
            end else if (w_deliver && ({1'b0, r_sram_addr} == r_byte_cnt)) begin
                r_byte_cnt <= r_byte_cnt + (RAM_AW+1)'(1);
            end

            if (w_rise) begin
                r_tmo_seen <= 1'b0;
            end else if (w_tmo_hit) begin
                r_tmo_seen <= 1'b1;
            end

            // A CPU write in the same cycle as the upload end wins over the clear.
            if (!ENABLE) begin
                r_dirty <= 1'b0;
            end else if (CART_RAM_WE) begin
                r_dirty <= 1'b1;
            end else if (w_fall && (r_byte_cnt == RAM_SIZE) && !r_tmo_seen) begin
                r_dirty <= 1'b0;
            end

            if (CART_RAM_WE || !r_dirty) begin
                r_quiet <= 24'd0;
            end else if (r_quiet != QUIET_CYC) begin
                r_quiet <= r_quiet + 24'd1;
            end

            r_upload_req <= r_dirty && (r_quiet == QUIET_CYC) && ENABLE && !bus.IOCTL_UPLOAD;
        end
    end

    assign bus.IOCTL_DIN  = r_din;
    assign bus.IOCTL_WAIT = r_wait;
    assign bus.SRAM_ADDR  = r_sram_addr;
    assign bus.SRAM_RD    = r_sram_rd;
    assign UPLOAD_REQ     = r_upload_req;
    assign DIRTY          = r_dirty;
    assign TIMEOUT_ERR    = r_tmo_err;

endmodule

// File: tb/tb_cart_ram_upload.sv
module tb_cart_ram_upload;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic we;
    logic upload_req;
    logic dirty;
    logic tmo_err;

    int n_assert = 0;
    int n_fail   = 0;
    int k;
    bit seen;

    cart_ram_upload_if #(.RAM_AW(13)) bus ();

    always #5 clk = ~clk;

    cart_ram_upload #(
        .RAM_AW      (13),
        .SAVE_INDEX  (8'd1),
        .QUIET_CYC   (24'd100),
        .TIMEOUT_CYC (8'd64)
    ) dut (
        .CLK_SYS     (clk),
        .RESET       (rst),
        .ENABLE      (enable),
        .CART_RAM_WE (we),
        .bus         (bus),
        .UPLOAD_REQ  (upload_req),
        .DIRTY       (dirty),
        .TIMEOUT_ERR (tmo_err)
    );

    // RAM preload pattern: byte i holds i ^ 8'h5A
    function automatic logic [7:0] ram(input logic [24:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        we = 1'b0;
        bus.IOCTL_UPLOAD = 1'b0;
        bus.IOCTL_INDEX  = 8'd1;
        bus.IOCTL_RD     = 1'b0;
        bus.IOCTL_ADDR   = 25'd0;
        bus.SRAM_DATA    = 8'h00;
        bus.SRAM_VALID   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic we_pulse();
        we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    // One ioctl read; the RAM answers with VALID in the lat-th cycle after RD.
    task automatic read_byte(input logic [24:0] a, input int lat, input bit full_chk);
        bus.IOCTL_RD   = 1'b1;
        bus.IOCTL_ADDR = a;
        @(negedge clk);
        bus.IOCTL_RD = 1'b0;
        if (full_chk) begin
            chk("sram_addr", 32'(bus.SRAM_ADDR), 32'(a[12:0]));
            chk("sram_rd_hi", 32'(bus.SRAM_RD), 32'd1);
        end
        for (int i = 1; i <= lat; i++) begin
            if (full_chk) chk("wait_hi", 32'(bus.IOCTL_WAIT), 32'd1);
            if (i == lat) begin
                bus.SRAM_VALID = 1'b1;
                bus.SRAM_DATA  = ram(a);
            end
            @(negedge clk);
        end
        bus.SRAM_VALID = 1'b0;
        bus.SRAM_DATA  = 8'h00;
        chk("wait_lo", 32'(bus.IOCTL_WAIT), 32'd0);
        chk("sram_rd_lo", 32'(bus.SRAM_RD), 32'd0);
        chk("din", 32'(bus.IOCTL_DIN), 32'(ram(a)));
    endtask

    initial begin
        enable = 1'b1;
        rst    = 1'b1;
        we     = 1'b0;
        bus.IOCTL_UPLOAD = 1'b0;
        bus.IOCTL_INDEX  = 8'd1;
        bus.IOCTL_RD     = 1'b0;
        bus.IOCTL_ADDR   = 25'd0;
        bus.SRAM_DATA    = 8'h00;
        bus.SRAM_VALID   = 1'b0;
        @(negedge clk);

        // Reset values
        chk("rst_din", 32'(bus.IOCTL_DIN), 32'hFF);
        chk("rst_wait", 32'(bus.IOCTL_WAIT), 32'd0);
        chk("rst_req", 32'(upload_req), 32'd0);
        chk("rst_sram_rd", 32'(bus.SRAM_RD), 32'd0);
        chk("rst_sram_addr", 32'(bus.SRAM_ADDR), 32'd0);
        chk("rst_dirty", 32'(dirty), 32'd0);
        chk("rst_tmo", 32'(tmo_err), 32'd0);

        // Single write: UPLOAD_REQ rises 101 edges after the write
        do_reset();
        we_pulse();
        chk("dirty_set", 32'(dirty), 32'd1);
        k = 0; seen = 1'b0;
        while (k < 400 && !seen) begin
            @(negedge clk);
            k++;
            if (upload_req) seen = 1'b1;
        end
        chk("req_delay", 32'(k), 32'd101);

        // Second write 50 edges later restarts the quiet period
        do_reset();
        we_pulse();
        k = 0; seen = 1'b0;
        while (k < 400 && !seen) begin
            @(negedge clk);
            k++;
            if (upload_req) seen = 1'b1;
            we = (k == 49);
        end
        we = 1'b0;
        chk("req_delay2", 32'(k), 32'd151);

        // Out-of-range read answers FF without stalling
        do_reset();
        bus.IOCTL_UPLOAD = 1'b1;
        @(negedge clk);
        read_byte(25'd5, 1, 1'b1);
        bus.IOCTL_RD = 1'b1; bus.IOCTL_ADDR = 25'd8192;
        @(negedge clk);
        bus.IOCTL_RD = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("oob_wait", 32'(bus.IOCTL_WAIT), 32'd0);
            chk("oob_sram_rd", 32'(bus.SRAM_RD), 32'd0);
            @(negedge clk);
        end
        chk("oob_din", 32'(bus.IOCTL_DIN), 32'hFF);

        // Fetch timeout: WAIT falls 65 cycles after RD
        do_reset();
        we_pulse();
        bus.IOCTL_UPLOAD = 1'b1;
        @(negedge clk);
        bus.IOCTL_RD = 1'b1; bus.IOCTL_ADDR = 25'd10;
        @(negedge clk);
        bus.IOCTL_RD = 1'b0;
        k = 1;
        chk("tmo_wait_hi", 32'(bus.IOCTL_WAIT), 32'd1);
        while (bus.IOCTL_WAIT && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("tmo_wait_len", 32'(k), 32'd65);
        chk("tmo_din", 32'(bus.IOCTL_DIN), 32'hFF);
        chk("tmo_err", 32'(tmo_err), 32'd1);
        chk("tmo_dirty", 32'(dirty), 32'd1);
        bus.IOCTL_UPLOAD = 1'b0;
        repeat (2) @(negedge clk);
        chk("tmo_dirty_end", 32'(dirty), 32'd1);

        // Abort after 100 bytes
        do_reset();
        we_pulse();
        bus.IOCTL_UPLOAD = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 100; a++) read_byte(25'(a), 1, 1'b0);
        bus.IOCTL_RD = 1'b1; bus.IOCTL_ADDR = 25'd100;
        @(negedge clk);
        bus.IOCTL_RD = 1'b0;
        chk("abort_wait_hi", 32'(bus.IOCTL_WAIT), 32'd1);
        bus.IOCTL_UPLOAD = 1'b0;
        @(negedge clk);
        chk("abort_wait", 32'(bus.IOCTL_WAIT), 32'd0);
        chk("abort_sram_rd", 32'(bus.SRAM_RD), 32'd0);
        bus.SRAM_VALID = 1'b1; bus.SRAM_DATA = 8'h00;
        @(negedge clk);
        bus.SRAM_VALID = 1'b0;
        chk("abort_late_valid", 32'(bus.IOCTL_DIN), 32'(ram(25'd99)));
        chk("abort_dirty", 32'(dirty), 32'd1);
        k = 0; seen = 1'b0;
        while (k < 200 && !seen) begin
            @(negedge clk);
            k++;
            if (upload_req) seen = 1'b1;
        end
        chk("abort_req", 32'(seen), 32'd1);

        // Full upload, VALID on 4th cycle after RD: DIRTY 1 -> 0
        do_reset();
        we_pulse();
        bus.IOCTL_UPLOAD = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 8192; a++) read_byte(25'(a), 4, 1'b1);
        chk("full_dirty_before", 32'(dirty), 32'd1);
        bus.IOCTL_UPLOAD = 1'b0;
        @(negedge clk);
        chk("full_dirty_after", 32'(dirty), 32'd0);
        chk("full_tmo", 32'(tmo_err), 32'd0);

        // Full upload again; a write coincides with the upload fall
        bus.IOCTL_UPLOAD = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 8192; a++) read_byte(25'(a), 1, 1'b0);
        bus.IOCTL_UPLOAD = 1'b0;
        we = 1'b1;
        @(negedge clk);
        we = 1'b0;
        chk("we_at_fall_dirty", 32'(dirty), 32'd1);

        // Wrong index: no response
        bus.IOCTL_UPLOAD = 1'b1; bus.IOCTL_INDEX = 8'd0;
        bus.IOCTL_RD = 1'b1; bus.IOCTL_ADDR = 25'd3;
        @(negedge clk);
        bus.IOCTL_RD = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("idx0_wait", 32'(bus.IOCTL_WAIT), 32'd0);
            chk("idx0_sram_rd", 32'(bus.SRAM_RD), 32'd0);
            @(negedge clk);
        end
        chk("idx0_din", 32'(bus.IOCTL_DIN), 32'(ram(25'd8191)));

        // ENABLE low forces DIRTY and UPLOAD_REQ low
        bus.IOCTL_UPLOAD = 1'b0; bus.IOCTL_INDEX = 8'd1;
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("dis_dirty", 32'(dirty), 32'd0);
        chk("dis_req", 32'(upload_req), 32'd0);

        // Reset mid-fetch returns outputs asynchronously
        enable = 1'b1;
        bus.IOCTL_UPLOAD = 1'b1;
        @(negedge clk);
        bus.IOCTL_RD = 1'b1; bus.IOCTL_ADDR = 25'd7;
        @(negedge clk);
        bus.IOCTL_RD = 1'b0;
        chk("mid_wait_hi", 32'(bus.IOCTL_WAIT), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_wait", 32'(bus.IOCTL_WAIT), 32'd0);
        chk("arst_sram_rd", 32'(bus.SRAM_RD), 32'd0);
        chk("arst_din", 32'(bus.IOCTL_DIN), 32'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
